cond_flag_unit: RTL

Consumer side of the ALU flag outputs. Holds the architectural NZCV flag register, written by flag-setting instructions (ADDS/SUBS/ANDS) in EX. Evaluates ARMv8 B.cond conditions for the instruction in ID, forwarding in-flight EX flags or requesting a one-cycle stall. Sits between the EX-stage ALU and the ID-stage branch logic of the 5-stage pipeline.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cond_eval.sv | 39 +++
 rtl/cond_flag_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, B.cond condition codes, NZCV bit positions.
package cpu_pkg;

   localparam logic [2:0] ALU_PASS_B   = 3'b000;
   localparam logic [2:0] ALU_ADD      = 3'b010;
   localparam logic [2:0] ALU_SUBTRACT = 3'b011;
   localparam logic [2:0] ALU_AND      = 3'b100;
   localparam logic [2:0] ALU_OR       = 3'b101;
   localparam logic [2:0] ALU_XOR      = 3'b110;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
      COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
      COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
      COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
   } cond_e;

   // Only arithmetic and logical ops may set flags.
   function automatic logic is_flag_op(input logic [2:0] cntrl);
      return (cntrl == ALU_ADD) || (cntrl == ALU_SUBTRACT) ||
             (cntrl == ALU_AND) || (cntrl == ALU_OR) || (cntrl == ALU_XOR);
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARMv8 condition evaluator on an NZCV vector.
module cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       cond_true
);

   logic n, z, c, v;

   always_comb begin
      n = flags[FLAG_N];
      z = flags[FLAG_Z];
      c = flags[FLAG_C];
      v = flags[FLAG_V];
      cond_true = 1'b0;
      case (cond_e'(cond))
         COND_EQ: cond_true = z;
         COND_NE: cond_true = ~z;
         COND_CS: cond_true = c;
         COND_CC: cond_true = ~c;
         COND_MI: cond_true = n;
         COND_PL: cond_true = ~n;
         COND_VS: cond_true = v;
         COND_VC: cond_true = ~v;
         COND_HI: cond_true = c & ~z;
         COND_LS: cond_true = ~c | z;
         COND_GE: cond_true = (n == v);
         COND_LT: cond_true = (n != v);
         COND_GT: cond_true = ~z & (n == v);
         COND_LE: cond_true = z | (n != v);
         COND_AL: cond_true = 1'b1;
         COND_NV: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register with EX-to-ID flag forwarding (or stall) for B.cond resolution.
module cond_flag_unit
   import cpu_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall_in,
   input  logic       ex_valid,
   input  logic       ex_flush,
   input  logic       ex_set_flags,
   input  logic [2:0] ex_alu_cntrl,
   input  logic       alu_negative,
   input  logic       alu_zero,
   input  logic       alu_overflow,
   input  logic       alu_carry_out,
   input  logic       id_valid,
   input  logic       id_is_bcond,
   input  logic [3:0] id_cond,
   output logic [3:0] flags_q,
   output logic       bcond_taken,
   output logic       bcond_resolved,
   output logic       flag_stall_req,
   output logic       flag_err
);

   logic       legal;
   logic       ex_live;
   logic       wr;
   logic       fwd;
   logic       id_bcond;
   logic       cond_true;
   logic [3:0] new_flags;
   logic [3:0] eval_flags;

   assign legal    = is_flag_op(ex_alu_cntrl);
   assign ex_live  = ex_valid & ex_set_flags & ~ex_flush;
   assign wr       = ex_live & ~stall_in;
   assign fwd      = ex_live & legal;
   assign id_bcond = id_valid & id_is_bcond;

   // Logical ops clear C and V; the ALU's C/V are ignored for them.
   always_comb begin
      new_flags = flags_q;
      case (ex_alu_cntrl)
         ALU_ADD, ALU_SUBTRACT:
            new_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
         ALU_AND, ALU_OR, ALU_XOR:
            new_flags = {alu_negative, alu_zero, 2'b00};
         default: new_flags = flags_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q  <= 4'b0000;
         flag_err <= 1'b0;
      end else begin
         if (wr && legal) flags_q <= new_flags;
         flag_err <= wr & ~legal;
      end
   end

   assign eval_flags = (FWD_EN && fwd) ? new_flags : flags_q;

   cond_eval u_cond_eval (
      .flags     (eval_flags),
      .cond      (id_cond),
      .cond_true (cond_true)
   );

   // Without forwarding, an in-flight flag write holds ID for one cycle until flags_q catches up.
   always_comb begin
      if (FWD_EN) begin
         flag_stall_req = 1'b0;
         bcond_resolved = id_bcond;
      end else begin
         flag_stall_req = id_bcond & fwd;
         bcond_resolved = id_bcond & ~flag_stall_req;
      end
      bcond_taken = bcond_resolved & cond_true;
   end

endmodule
